// File: rtl/pm_step_gen.sv
// rtl/pm_step_gen.sv - plus/minus buttons to debounced, auto-repeating up/down step pulses
module pm_step_gen #(
  parameter int DB_CYCLES     = 500000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic on,
  input  logic btn_up,
  input  logic btn_down,
  output logic up_count,
  output logic down_count,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES - 1);

  // Bit 0 carries the plus button, bit 1 the minus button throughout.
  logic [1:0] btn;
  logic [1:0] sync1;
  logic [1:0] s;
  logic [1:0] f;
  logic [1:0] f_d;
  logic [1:0] arm;
  logic [1:0] r;
  logic [1:0] vld;
  logic [1:0][CNT_W-1:0] db_cnt;

  state_t            state, state_n;
  logic              dir, dir_n;     // 0 = up, 1 = down
  logic [CNT_W-1:0]  timer, timer_n;
  logic              up_n, down_n;
  logic              f_dir, f_oth;
  logic              abort;

  assign btn = {btn_down, btn_up};

  // Two-flop synchronizer; vld marks when the second stage holds a real sample after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      s     <= '0;
      vld   <= '0;
    end else begin
      sync1 <= btn;
      s     <= sync1;
      vld   <= {vld[0], 1'b1};
    end
  end

  // Debounce: the filtered level follows the synced input only after it has differed
  // for DB_CYCLES consecutive cycles; any return to the filtered level restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f      <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] == f[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          f[i]      <= s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered press edge. A button is armed only once it has been seen released after
  // reset, so a button held through reset cannot produce a press edge when its filtered
  // level first rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_d <= '0;
      arm <= '0;
      r   <= '0;
    end else begin
      f_d <= f;
      arm <= arm | ({2{vld[1]}} & ~s);
      r   <= f & ~f_d & arm;
    end
  end

  assign f_dir = dir ? f[1] : f[0];
  assign f_oth = dir ? f[0] : f[1];
  assign abort = ~on | ~f_dir | f_oth;

  // FSM next-state: first pulse on a clean press, then hold delay, then periodic repeat.
  always_comb begin
    state_n = state;
    dir_n   = dir;
    timer_n = timer;
    up_n    = 1'b0;
    down_n  = 1'b0;
    case (state)
      IDLE: begin
        if (on && r[0] && !f[1]) begin
          up_n    = 1'b1;
          dir_n   = 1'b0;
          timer_n = HOLD_MAX;
          state_n = HOLD;
        end else if (on && r[1] && !f[0]) begin
          down_n  = 1'b1;
          dir_n   = 1'b1;
          timer_n = HOLD_MAX;
          state_n = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (timer == '0) begin
          up_n    = ~dir;
          down_n  = dir;
          timer_n = REP_MAX;
          state_n = REPEAT;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state, timer and registered pulse / busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      timer      <= '0;
      up_count   <= 1'b0;
      down_count <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      timer      <= timer_n;
      up_count   <= up_n;
      down_count <= down_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule
